// File: rtl/mem_bus_arbiter_if.sv
// Requester-side line bus channel: command/address/write beat out from the master,
// grant, write-ready, read beats and completion back from the arbiter.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) ();
  logic [1:0]        cmd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              wready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              done;

  modport master (
    output cmd, addr, wdata,
    input  gnt, wready, rvalid, rdata, done
  );

  modport slave (
    input  cmd, addr, wdata,
    output gnt, wready, rvalid, rdata, done
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the cache-to-memory line bus between two requesters,
// holding the grant for a whole line transfer and flagging memory timeouts.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 16,
  parameter int BEATS   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  mem_bus_arbiter_if.slave  m0_if,
  mem_bus_arbiter_if.slave  m1_if,
  output logic [1:0]        mem_cmd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_resp_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int BCNT_W = $clog2(BEATS) + 1;
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WR_BEAT = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_RD_BEAT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ptr_q, ptr_d;
  logic [BCNT_W-1:0] beat_q, beat_d;
  logic [TCNT_W-1:0] tmo_q, tmo_d;
  logic              err_q, err_d;

  logic              req0, req1, win;
  logic [TCNT_W-1:0] tmo_inc;
  logic              last_beat;

  assign req0      = m0_if.cmd[1];
  assign req1      = m1_if.cmd[1];
  assign win       = (req0 && req1) ? ptr_q : req1;
  assign tmo_inc   = tmo_q + TCNT_W'(1);
  assign last_beat = (beat_q == BCNT_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    write_d = write_q;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d = win;
          write_d = win ? m1_if.cmd[0] : m0_if.cmd[0];
          addr_d  = win ? m1_if.addr : m0_if.addr;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        beat_d  = write_q ? BCNT_W'(1) : '0;
        state_d = write_q ? S_WR_BEAT : S_WAIT;
      end
      S_WR_BEAT: begin
        beat_d = beat_q + BCNT_W'(1);
        if (last_beat) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_i) begin
          tmo_d = '0;
          if (write_q) begin
            state_d = S_DONE;
          end else begin
            beat_d  = BCNT_W'(1);
            state_d = S_RD_BEAT;
          end
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TCNT_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RD_BEAT: begin
        if (mem_resp_i) begin
          tmo_d  = '0;
          beat_d = beat_q + BCNT_W'(1);
          if (last_beat) state_d = S_DONE;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TCNT_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        ptr_d   = ~owner_q;
        tmo_d   = '0;
        beat_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      ptr_q   <= 1'b0;
      beat_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // A write acknowledge in WAIT is not a read beat, so it is never forwarded.
  logic gnt, wready, rvalid, done;
  assign gnt    = (state_q == S_ISSUE);
  assign wready = (gnt && write_q) || (state_q == S_WR_BEAT);
  assign rvalid = mem_resp_i && (((state_q == S_WAIT) && !write_q) || (state_q == S_RD_BEAT));
  assign done   = (state_q == S_DONE);

  always_comb begin
    mem_cmd_o = 2'b00;
    if (gnt) mem_cmd_o = {1'b1, write_q};
    else if (state_q == S_WR_BEAT) mem_cmd_o = 2'b11;
  end

  assign mem_addr_o  = busy_o ? addr_q : '0;
  assign mem_wdata_o = wready ? (owner_q ? m1_if.wdata : m0_if.wdata) : '0;
  assign busy_o      = (state_q != S_IDLE);
  assign err_o       = err_q;

  assign m0_if.gnt    = gnt && !owner_q;
  assign m0_if.wready = wready && !owner_q;
  assign m0_if.rvalid = rvalid && !owner_q;
  assign m0_if.rdata  = m0_if.rvalid ? mem_rdata_i : '0;
  assign m0_if.done   = done && !owner_q;

  assign m1_if.gnt    = gnt && owner_q;
  assign m1_if.wready = wready && owner_q;
  assign m1_if.rvalid = rvalid && owner_q;
  assign m1_if.rdata  = m1_if.rvalid ? mem_rdata_i : '0;
  assign m1_if.done   = done && owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single read, write burst, contention,
// gapped read, timeout and reset in the middle of a read.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  mem_cmd;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        err;

  int testCount = 0;
  int failCount = 0;

  mem_bus_arbiter_if #(.ADDR_W(15), .DATA_W(16)) m0_bus ();
  mem_bus_arbiter_if #(.ADDR_W(15), .DATA_W(16)) m1_bus ();

  mem_bus_arbiter dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .m0_if       (m0_bus),
    .m1_if       (m1_bus),
    .mem_cmd_o   (mem_cmd),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_resp_i  (mem_resp),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic gntOf(input bit m);
    return m ? m1_bus.gnt : m0_bus.gnt;
  endfunction

  function automatic logic wreadyOf(input bit m);
    return m ? m1_bus.wready : m0_bus.wready;
  endfunction

  function automatic logic rvalidOf(input bit m);
    return m ? m1_bus.rvalid : m0_bus.rvalid;
  endfunction

  function automatic logic [15:0] rdataOf(input bit m);
    return m ? m1_bus.rdata : m0_bus.rdata;
  endfunction

  function automatic logic doneOf(input bit m);
    return m ? m1_bus.done : m0_bus.done;
  endfunction

  task automatic applyStimulus(input bit m, input logic [1:0] cmd, input logic [14:0] addr,
                               input logic [15:0] wdata);
    if (m) begin
      m1_bus.cmd = cmd; m1_bus.addr = addr; m1_bus.wdata = wdata;
    end else begin
      m0_bus.cmd = cmd; m0_bus.addr = addr; m0_bus.wdata = wdata;
    end
  endtask

  task automatic setCmd(input bit m, input logic [1:0] cmd);
    if (m) m1_bus.cmd = cmd;
    else   m0_bus.cmd = cmd;
  endtask

  task automatic setWdata(input bit m, input logic [15:0] wdata);
    if (m) m1_bus.wdata = wdata;
    else   m0_bus.wdata = wdata;
  endtask

  task automatic expectIssue(input bit m, input logic [1:0] cmd, input logic [14:0] addr);
    checkOutput("issue_gnt", 32'(gntOf(m)), 32'd1);
    checkOutput("issue_other_gnt", 32'(gntOf(!m)), 32'd0);
    checkOutput("issue_mem_cmd", 32'(mem_cmd), 32'(cmd));
    checkOutput("issue_mem_addr", 32'(mem_addr), 32'(addr));
    checkOutput("issue_busy", 32'(busy), 32'd1);
  endtask

  // Starts on the first WAIT cycle, ends after checking the DONE cycle.
  task automatic readBeats(input bit m, input logic [15:0] base, input int lead, input bit gapped);
    bit pat[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int beats = 0;
    bit r;
    for (int cyc = 0; beats < 8 && cyc < lead + 40; cyc++) begin
      if (cyc < lead) r = 1'b0;
      else if (gapped && (cyc - lead) < 10) r = pat[cyc - lead];
      else r = 1'b1;
      mem_resp  = r;
      mem_rdata = base + 16'(beats);
      #1;
      checkOutput("rd_rvalid", 32'(rvalidOf(m)), 32'(r));
      checkOutput("rd_other_rvalid", 32'(rvalidOf(!m)), 32'd0);
      checkOutput("rd_rdata", 32'(rdataOf(m)), r ? 32'(base + 16'(beats)) : 32'd0);
      checkOutput("rd_no_early_done", 32'(doneOf(m)), 32'd0);
      if (r) beats++;
      step();
    end
    mem_resp  = 1'b0;
    mem_rdata = 16'h0;
    #1;
    checkOutput("rd_done", 32'(doneOf(m)), 32'd1);
    checkOutput("rd_other_done", 32'(doneOf(!m)), 32'd0);
    checkOutput("rd_done_rvalid", 32'(rvalidOf(m)), 32'd0);
  endtask

  // Starts on the ISSUE cycle with beat 0 already on WDATA, ends on the first WAIT cycle.
  task automatic writeBeats(input bit m, input logic [15:0] base);
    checkOutput("wr_wdata0", 32'(mem_wdata), 32'(base));
    checkOutput("wr_wready0", 32'(wreadyOf(m)), 32'd1);
    checkOutput("wr_other_wready", 32'(wreadyOf(!m)), 32'd0);
    setCmd(m, 2'd0);
    for (int i = 1; i < 8; i++) begin
      step();
      setWdata(m, base + 16'(i));
      #1;
      checkOutput("wr_mem_cmd", 32'(mem_cmd), 32'd3);
      checkOutput("wr_mem_wdata", 32'(mem_wdata), 32'(base + 16'(i)));
      checkOutput("wr_wready", 32'(wreadyOf(m)), 32'd1);
    end
    step();
    checkOutput("wr_wait_cmd", 32'(mem_cmd), 32'd0);
    checkOutput("wr_wait_wready", 32'(wreadyOf(m)), 32'd0);
  endtask

  task automatic writeAck(input bit m, input int delay);
    for (int k = 0; k < delay; k++) begin
      mem_resp = 1'b0;
      #1;
      checkOutput("ack_no_done", 32'(doneOf(m)), 32'd0);
      step();
    end
    mem_resp = 1'b1;
    #1;
    checkOutput("ack_rvalid", 32'(rvalidOf(m)), 32'd0);
    step();
    mem_resp = 1'b0;
    #1;
    checkOutput("ack_done", 32'(doneOf(m)), 32'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_resp  = 1'b0;
    mem_rdata = 16'h0;
    applyStimulus(1'b0, 2'd0, 15'h0, 16'h0);
    applyStimulus(1'b1, 2'd0, 15'h0, 16'h0);
    step();
    step();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_mem_cmd", 32'(mem_cmd), 32'd0);
    checkOutput("reset_gnt0", 32'(m0_bus.gnt), 32'd0);
    reset_n = 1'b1;

    $display("[TB] single read");
    applyStimulus(1'b0, 2'd2, 15'h0123, 16'h0);
    #1;
    checkOutput("idle_no_gnt", 32'(m0_bus.gnt), 32'd0);
    step();
    expectIssue(1'b0, 2'd2, 15'h0123);
    setCmd(1'b0, 2'd0);
    step();
    readBeats(1'b0, 16'hA000, 20, 1'b0);
    step();
    checkOutput("read_idle_busy", 32'(busy), 32'd0);
    checkOutput("read_done_pulse", 32'(m0_bus.done), 32'd0);

    $display("[TB] write burst");
    applyStimulus(1'b1, 2'd3, 15'h7FFF, 16'hB000);
    step();
    expectIssue(1'b1, 2'd3, 15'h7FFF);
    writeBeats(1'b1, 16'hB000);
    writeAck(1'b1, 10);
    step();
    checkOutput("write_idle_busy", 32'(busy), 32'd0);

    $display("[TB] contention");
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    applyStimulus(1'b0, 2'd2, 15'h0100, 16'h0);
    applyStimulus(1'b1, 2'd3, 15'h0200, 16'hC000);
    step();
    expectIssue(1'b0, 2'd2, 15'h0100);
    setCmd(1'b0, 2'd0);
    step();
    readBeats(1'b0, 16'hD000, 2, 1'b0);
    step();
    checkOutput("cont_dead_busy", 32'(busy), 32'd0);
    checkOutput("cont_dead_gnt1", 32'(m1_bus.gnt), 32'd0);
    step();
    expectIssue(1'b1, 2'd3, 15'h0200);
    writeBeats(1'b1, 16'hC000);
    writeAck(1'b1, 3);
    step();
    applyStimulus(1'b0, 2'd2, 15'h0300, 16'h0);
    applyStimulus(1'b1, 2'd2, 15'h0400, 16'h0);
    step();
    expectIssue(1'b0, 2'd2, 15'h0300);
    setCmd(1'b0, 2'd0);
    step();

    $display("[TB] gapped read");
    readBeats(1'b0, 16'hE000, 0, 1'b1);
    step();
    checkOutput("gap_idle_busy", 32'(busy), 32'd0);
    step();
    expectIssue(1'b1, 2'd2, 15'h0400);
    setCmd(1'b1, 2'd0);
    step();
    readBeats(1'b1, 16'hF000, 1, 1'b0);
    step();

    $display("[TB] timeout");
    applyStimulus(1'b0, 2'd2, 15'h0555, 16'h0);
    step();
    expectIssue(1'b0, 2'd2, 15'h0555);
    setCmd(1'b0, 2'd0);
    step();
    checkOutput("tmo_err_before", 32'(err), 32'd0);
    for (int c = 0; c < 254; c++) step();
    checkOutput("tmo_last_wait_done", 32'(m0_bus.done), 32'd0);
    checkOutput("tmo_last_wait_busy", 32'(busy), 32'd1);
    checkOutput("tmo_last_wait_err", 32'(err), 32'd0);
    step();
    checkOutput("tmo_done", 32'(m0_bus.done), 32'd1);
    checkOutput("tmo_err", 32'(err), 32'd1);
    step();
    checkOutput("tmo_idle_busy", 32'(busy), 32'd0);
    checkOutput("tmo_err_sticky", 32'(err), 32'd1);
    applyStimulus(1'b0, 2'd2, 15'h0666, 16'h0);
    step();
    expectIssue(1'b0, 2'd2, 15'h0666);
    setCmd(1'b0, 2'd0);
    step();
    readBeats(1'b0, 16'h1000, 3, 1'b0);
    step();
    checkOutput("err_after_good_txn", 32'(err), 32'd1);

    $display("[TB] reset mid-read");
    applyStimulus(1'b0, 2'd2, 15'h00AA, 16'h0);
    step();
    expectIssue(1'b0, 2'd2, 15'h00AA);
    setCmd(1'b0, 2'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      mem_resp  = 1'b1;
      mem_rdata = 16'h2000 + 16'(i);
      #1;
      checkOutput("mid_rvalid", 32'(m0_bus.rvalid), 32'd1);
      step();
    end
    reset_n   = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = 16'h2004;
    step();
    reset_n  = 1'b1;
    mem_resp = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_mem_cmd", 32'(mem_cmd), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_rvalid", 32'(m0_bus.rvalid), 32'd0);
    checkOutput("rst_done", 32'(m0_bus.done), 32'd0);
    checkOutput("rst_gnt", 32'(m0_bus.gnt), 32'd0);
    applyStimulus(1'b0, 2'd2, 15'h0011, 16'h0);
    applyStimulus(1'b1, 2'd3, 15'h0022, 16'h3000);
    #1;
    checkOutput("rst_no_late_done", 32'(m0_bus.done), 32'd0);
    step();
    expectIssue(1'b0, 2'd2, 15'h0011);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single cache-to-memory line bus (MemCTR side, C2/A2/D2 protocol) between two requesters: master 0 is the cache, master 1 is a secondary line mover (prefetcher/DMA).
- Arbitrates per transaction with round-robin priority and holds the grant for the whole line transfer.
- Sequences command issue, write beats, read beats and completion.
- Flags memory timeouts.

Parameters:
- ADDR_W, 15, line address width (matches A2).
- DATA_W, 16, beat width (matches D2).
- BEATS, 8, beats per line (16-byte line / 2-byte beat).
- TIMEOUT, 255, maximum cycles without a memory response beat before abort.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  synchronous, active-low reset.
- M0_CMD  in  2  master 0 command: 0 NOP, 1 reserved (treated as NOP), 2 READ_LINE, 3 WRITE_LINE.
- M0_ADDR  in  ADDR_W  master 0 line address.
- M0_WDATA  in  DATA_W  master 0 write beat.
- M0_GNT  out  1  master 0 command accepted (1-cycle pulse).
- M0_WREADY  out  1  current M0_WDATA beat consumed this cycle.
- M0_RVALID  out  1  M0_RDATA holds a valid read beat.
- M0_RDATA  out  DATA_W  read beat to master 0.
- M0_DONE  out  1  master 0 transaction complete (1-cycle pulse).
- M1_CMD, M1_ADDR, M1_WDATA, M1_GNT, M1_WREADY, M1_RVALID, M1_RDATA, M1_DONE: identical set for master 1.
- MEM_CMD  out  2  command to memory controller (same encoding).
- MEM_ADDR  out  ADDR_W  address to memory controller.
- MEM_WDATA  out  DATA_W  write beat to memory controller.
- MEM_RESP  in  1  memory controller RESPONSE: read beat valid, or write acknowledge.
- MEM_RDATA  in  DATA_W  read beat from memory controller.
- BUSY  out  1  high in every state except IDLE.
- ERR  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (RESET=0 at posedge, any state, including mid-transfer):
  - State goes to IDLE; priority pointer selects master 0.
  - Beat counter and timeout counter are cleared; ERR=0.
  - All outputs are 0; MEM_CMD=NOP.
  - An in-flight transfer is abandoned with no DONE pulse.
- States: IDLE, ISSUE, WR_BEAT, WAIT, RD_BEAT, DONE.
- IDLE:
  - A master requests when its CMD is 2 or 3.
  - One requester: that master wins.
  - Both request: the master selected by the pointer wins.
  - The winner's CMD and ADDR are latched into the owner registers; next state is ISSUE.
  - No request: remain in IDLE.
- ISSUE (1 cycle):
  - MEM_CMD=latched command, MEM_ADDR=latched address, owner Mx_GNT=1.
  - For WRITE: MEM_WDATA=owner WDATA (beat 0), owner WREADY=1; next state is WR_BEAT with beat count 1.
  - For READ: next state is WAIT.
- WR_BEAT:
  - MEM_CMD=WRITE; MEM_WDATA=owner WDATA; owner WREADY=1 each cycle.
  - Lasts BEATS-1 cycles, covering beats 1..BEATS-1 back-to-back; then WAIT.
  - The master advances WDATA on the cycle after each WREADY.
- WAIT:
  - MEM_CMD=NOP; the timeout counter increments every cycle.
  - WRITE owner: MEM_RESP=1 is the acknowledge; go to DONE.
  - READ owner: the first MEM_RESP=1 cycle is beat 0 and is forwarded that same cycle (RVALID=1, RDATA=MEM_RDATA); go to RD_BEAT with count 1.
- RD_BEAT:
  - Each MEM_RESP=1 cycle forwards a beat combinationally and increments the count.
  - Gaps (MEM_RESP=0) are allowed.
  - After beat BEATS-1, go to DONE.
- Timeout:
  - The counter resets on every beat or acknowledge.
  - If it reaches TIMEOUT in WAIT or RD_BEAT: set ERR, go to DONE; owner receives DONE with no further beats.
- DONE (1 cycle):
  - Owner Mx_DONE=1.
  - Pointer is set to the other master.
  - Return to IDLE. A new grant is possible on the next cycle, so there is at least one dead cycle between transactions.
- Inputs and outputs during a transaction:
  - Non-owner requests are ignored; the non-owner's GNT, WREADY, RVALID and DONE stay 0.
  - Owner CMD changes after GNT are ignored, since command and address are latched.
  - Mx_RDATA=MEM_RDATA when Mx_RVALID=1, else 0.
  - MEM_RESP seen in IDLE, ISSUE or DONE is ignored.
- Widths: beat counter is clog2(BEATS)+1 bits; timeout counter is clog2(TIMEOUT+1) bits; neither counter wraps.

Test Plan:
- Single read: M0_CMD=2, ADDR=0x0123.
  - Next cycle: MEM_CMD=2, MEM_ADDR=0x0123, M0_GNT=1.
  - Memory returns 8 beats 0xA000..0xA007 after 20 cycles → M0_RVALID on exactly 8 cycles with matching data, then M0_DONE=1 for 1 cycle, BUSY=0.
- Write burst: M1_CMD=3, ADDR=0x7FFF, WDATA stepping 0xB000..0xB007.
  - MEM_CMD=3 for 8 consecutive cycles carrying 0xB000..0xB007; M1_WREADY high on exactly those 8 cycles.
  - A 1-cycle MEM_RESP 10 cycles later → M1_DONE pulse.
- Contention: M0 and M1 request in the same cycle after reset.
  - M0 is granted first; M1 is granted in the first IDLE after M0_DONE.
  - Both request again → M0 wins (pointer alternation).
- Gapped read: MEM_RESP pattern 1,0,0,1,1,0,1,1,1,1 → exactly 8 RVALID beats; DONE only after the 8th beat.
- Timeout: read issued, MEM_RESP held 0 → after 255 cycles in WAIT, ERR=1 and M0_DONE pulse. ERR stays 1 through the next successful transaction.
- Reset mid-read: RESET=0 after beat 3.
  - Next cycle: all outputs 0, BUSY=0, no DONE.
  - After release, simultaneous requests grant M0.
